hi_low_solver: RTL and testbench
================================

// Module: hi_low_solver
// PURPOSE
//  Automatic player for the hi/low game. Drives 4-bit guesses into the game, reads the
//  game's H/L/I seven-segment response and bisects the range until it reads I (win) or
//  runs out of guesses. Sits opposite the game module, on its guessSwitch/hiLowBut inputs
//  and its hiLowSeg output. Used for self-play demos and as a bench driver.
// PARAMETERS
//  W          4   guess width; search range is 0..2^W-1
//  MAX_GUESS  5   guess budget; must be >= W+1 so the search always completes
//  SETTLE     3   clocks from guessStrobe to hiLowSeg sample, 1..15
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   level; sampled only in IDLE; starts a new game
//  hiLowSeg    in   7   game response, segment index [6:0]=g..a, active-low
//  guess       out  W   current guess, drives guessSwitch
//  guessStrobe out  1   1-cycle pulse, drives hiLowBut
//  guessCount  out  3   guesses issued this game
//  done        out  1   high in DONE and ERR states
//  win         out  1   high in DONE when the last response was I
//  decodeErr   out  1   high in ERR: unknown pattern or contradictory response
// BEHAVIOUR
//  Reset (sync): state=IDLE, lo=0, hi=2^W-1, guess=0, guessStrobe=0, guessCount=0,
//  done=0, win=0, decodeErr=0. Reset wins over every other event, in every state.
//  Bounds lo and hi are W+1 bits wide. mid=(lo+hi)>>1, computed in W+1 bits; guess=mid[W-1:0].
//  Patterns, active-low: H=7'b0001001 (guess > secret), L=7'b1000111 (guess < secret),
//  I=7'b1111001 (win). Any other value is unknown.
//  States:
//   IDLE   : start=1 -> lo=0, hi=2^W-1, guessCount=0, done/win/decodeErr=0 -> DRIVE
//   DRIVE  : guess<=mid, guessStrobe=1 for exactly this cycle, guessCount+=1 -> WAIT
//   WAIT   : guess held stable; after SETTLE clocks -> SAMPLE
//   SAMPLE : decode hiLowSeg, registered, one cycle:
//            I -> win=1 -> DONE
//            H -> if mid==lo -> ERR, else hi=mid-1
//            L -> if mid==hi -> ERR, else lo=mid+1
//            unknown -> ERR
//            H/L with no error: if guessCount==MAX_GUESS -> DONE (win=0), else -> DRIVE
//   DONE   : done=1; start=0 -> IDLE; while start stays high, remain in DONE (no auto-replay)
//   ERR    : done=1, decodeErr=1; same exit rule as DONE
//  Latency from DRIVE to the next DRIVE: SETTLE+2 clocks.
//  guess holds its last value in DONE and ERR.
//  Boundaries:
//   - lo=hi: mid=lo; I is the only consistent response, and H or L -> ERR.
//   - No bound leaves 0..2^W-1, which is what the ERR checks enforce.
//   - start in any state other than IDLE/DONE/ERR is ignored.
//   - Changes on hiLowSeg outside SAMPLE are ignored.
// CONFIGURATION
//  SOLVER_SEG_ACTIVE_HIGH_EN defined: hiLowSeg is decoded active-high, so
//  H=7'b1110110, L=7'b0111000, I=7'b0000110. Undefined: active-low encodings above.
//  No other behaviour changes.
// TESTING
//  1 Secret 0xB: guesses 7 (L), 11 (I) -> win=1, done=1, guessCount=2.
//  2 Secret 0x0: guesses 7, 3, 1 (H each), then 0 (I) -> win=1, guessCount=4.
//  3 Secret 0xF: guesses 7, 11, 13, 14 (L each), then 15 (I) -> win=1, guessCount=5.
//  4 hiLowSeg=7'b1111111 at the first SAMPLE -> ERR: decodeErr=1, done=1, guess=7.
//  5 Responder always returns L -> guesses 7, 11, 13, 14, 15; L at guess 15 (mid==hi)
//    -> ERR, guessCount=5.
//  6 reset pulsed in WAIT of the 2nd guess -> next clock all outputs at reset values,
//    state=IDLE; start with secret 0xB -> case 1 result; also check guessStrobe is
//    exactly 1 cycle and SETTLE+2 clocks between strobes.

Source files
------------

// File: rtl/hi_low_solver_if.sv
// Guess/response link between the hi/low solver (master) and the game (slave).
// The solver drives guess and guessStrobe; the game answers on hiLowSeg.
interface hi_low_solver_if #(
    parameter int W = 4
);
    logic [W-1:0] guess;
    logic         guessStrobe;
    logic [6:0]   hiLowSeg;

    modport master (
        output guess,
        output guessStrobe,
        input  hiLowSeg
    );

    modport slave (
        input  guess,
        input  guessStrobe,
        output hiLowSeg
    );
endinterface

// File: rtl/hi_low_solver.sv
// Automatic hi/low player: bisects 0..2^W-1 using the game's H/L/I segment response.
// Define SOLVER_SEG_ACTIVE_HIGH_EN to decode hiLowSeg as active-high segments.
module hi_low_solver #(
    parameter int W         = 4,
    parameter int MAX_GUESS = 5,
    parameter int SETTLE    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    hi_low_solver_if.master     bus,
    output logic [2:0]          guessCount,
    output logic                done,
    output logic                win,
    output logic                decodeErr
);
`ifdef SOLVER_SEG_ACTIVE_HIGH_EN
    localparam logic [6:0] SEG_H = 7'b1110110;
    localparam logic [6:0] SEG_L = 7'b0111000;
    localparam logic [6:0] SEG_I = 7'b0000110;
`else
    localparam logic [6:0] SEG_H = 7'b0001001;
    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_I = 7'b1111001;
`endif

    localparam logic [W:0] HI_INIT     = {1'b0, {W{1'b1}}};
    localparam logic [W:0] BOUND_ONE   = (W+1)'(1);
    localparam logic [2:0] MAX_CNT     = 3'(MAX_GUESS);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RESP_UNKNOWN = 2'd0,
        RESP_H       = 2'd1,
        RESP_L       = 2'd2,
        RESP_I       = 2'd3
    } resp_t;

    state_t     state_r;
    logic [W:0] lo_r;
    logic [W:0] hi_r;
    logic [W:0] mid_s;
    logic [3:0] settle_r;
    resp_t      resp_s;

    // Midpoint in W+1 bits so lo+hi never overflows.
    always_comb begin
        mid_s = (lo_r + hi_r) >> 1;
    end

    // Classify the game response.
    always_comb begin
        if (bus.hiLowSeg == SEG_I) begin
            resp_s = RESP_I;
        end else if (bus.hiLowSeg == SEG_H) begin
            resp_s = RESP_H;
        end else if (bus.hiLowSeg == SEG_L) begin
            resp_s = RESP_L;
        end else begin
            resp_s = RESP_UNKNOWN;
        end
    end

    // Solver FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            lo_r            <= '0;
            hi_r            <= HI_INIT;
            settle_r        <= 4'd0;
            bus.guess       <= '0;
            bus.guessStrobe <= 1'b0;
            guessCount      <= 3'd0;
            done            <= 1'b0;
            win             <= 1'b0;
            decodeErr       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    bus.guessStrobe <= 1'b0;
                    if (start) begin
                        lo_r       <= '0;
                        hi_r       <= HI_INIT;
                        guessCount <= 3'd0;
                        done       <= 1'b0;
                        win        <= 1'b0;
                        decodeErr  <= 1'b0;
                        state_r    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    bus.guess       <= mid_s[W-1:0];
                    bus.guessStrobe <= 1'b1;
                    guessCount      <= guessCount + 3'd1;
                    settle_r        <= 4'd0;
                    state_r         <= S_WAIT;
                end
                S_WAIT: begin
                    bus.guessStrobe <= 1'b0;
                    if (settle_r == SETTLE_LAST) begin
                        state_r <= S_SAMPLE;
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    // A bound that would leave the range means the game contradicted itself.
                    case (resp_s)
                        RESP_I: begin
                            win     <= 1'b1;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end
                        RESP_H: begin
                            if (mid_s == lo_r) begin
                                done      <= 1'b1;
                                decodeErr <= 1'b1;
                                state_r   <= S_ERR;
                            end else begin
                                hi_r <= mid_s - BOUND_ONE;
                                if (guessCount == MAX_CNT) begin
                                    done    <= 1'b1;
                                    state_r <= S_DONE;
                                end else begin
                                    state_r <= S_DRIVE;
                                end
                            end
                        end
                        RESP_L: begin
                            if (mid_s == hi_r) begin
                                done      <= 1'b1;
                                decodeErr <= 1'b1;
                                state_r   <= S_ERR;
                            end else begin
                                lo_r <= mid_s + BOUND_ONE;
                                if (guessCount == MAX_CNT) begin
                                    done    <= 1'b1;
                                    state_r <= S_DONE;
                                end else begin
                                    state_r <= S_DRIVE;
                                end
                            end
                        end
                        default: begin
                            done      <= 1'b1;
                            decodeErr <= 1'b1;
                            state_r   <= S_ERR;
                        end
                    endcase
                end
                S_DONE, S_ERR: begin
                    // Holding start high parks here; no automatic replay.
                    if (!start) begin
                        done      <= 1'b0;
                        win       <= 1'b0;
                        decodeErr <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hi_low_solver.sv
// Directed table-driven bench for hi_low_solver with a behavioural hi/low game responder.
module tb_hi_low_solver;
    localparam int W = 4;
    localparam int SETTLE = 3;

`ifdef SOLVER_SEG_ACTIVE_HIGH_EN
    localparam logic [6:0] SEG_H = 7'b1110110;
    localparam logic [6:0] SEG_L = 7'b0111000;
    localparam logic [6:0] SEG_I = 7'b0000110;
`else
    localparam logic [6:0] SEG_H = 7'b0001001;
    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_I = 7'b1111001;
`endif

    localparam logic [1:0] M_GAME = 2'd0;
    localparam logic [1:0] M_ALWL = 2'd1;
    localparam logic [1:0] M_ALWH = 2'd2;
    localparam logic [1:0] M_BAD  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] guessCount;
    logic       done;
    logic       win;
    logic       decodeErr;
    logic [3:0] secret;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    hi_low_solver_if #(.W(W)) bus ();

    hi_low_solver #(.W(W), .MAX_GUESS(5), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.master),
        .guessCount (guessCount),
        .done       (done),
        .win        (win),
        .decodeErr  (decodeErr)
    );

    always #5 clk = ~clk;

    // Game model: answers the current guess against the secret, or a forced pattern.
    always @* begin
        case (mode)
            M_GAME:  bus.hiLowSeg = (bus.guess > secret) ? SEG_H :
                                    (bus.guess < secret) ? SEG_L : SEG_I;
            M_ALWL:  bus.hiLowSeg = SEG_L;
            M_ALWH:  bus.hiLowSeg = SEG_H;
            default: bus.hiLowSeg = 7'b1111111;
        endcase
    end

    // Strobe monitor: guess history, strobe width and strobe-to-strobe spacing.
    logic [19:0] seq = 20'd0;
    int cyc = 0;
    int prev_cyc = 0;
    int last_gap = 0;
    int bad_gap = 0;
    int wide = 0;
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_strobe <= bus.guessStrobe;
        if (bus.guessStrobe && prev_strobe) wide <= wide + 1;
        if (bus.guessStrobe && !prev_strobe) begin
            if (guessCount == 3'd1) begin
                seq <= {16'd0, bus.guess};
            end else begin
                seq <= {seq[15:0], bus.guess};
                last_gap <= cyc - prev_cyc;
                if (cyc - prev_cyc != SETTLE + 2) bad_gap <= bad_gap + 1;
            end
            prev_cyc <= cyc;
        end
    end

    typedef struct {
        string      name;
        logic [3:0] secret;
        logic [1:0] mode;
        logic       exp_win;
        logic       exp_err;
        logic [2:0] exp_count;
        logic [3:0] exp_guess;
        logic [19:0] exp_seq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_game(input vec_t v);
        logic ok;
        secret = v.secret;
        mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({v.name, ".timeout"}, {31'd0, ok}, 32'd1);
        chk({v.name, ".win"}, {31'd0, win}, {31'd0, v.exp_win});
        chk({v.name, ".err"}, {31'd0, decodeErr}, {31'd0, v.exp_err});
        chk({v.name, ".count"}, {29'd0, guessCount}, {29'd0, v.exp_count});
        chk({v.name, ".guess"}, {28'd0, bus.guess}, {28'd0, v.exp_guess});
        chk({v.name, ".seq"}, {12'd0, seq}, {12'd0, v.exp_seq});
        @(negedge clk);
        @(negedge clk);
        chk({v.name, ".hold"}, {31'd0, done}, 32'd1);
        chk({v.name, ".nostrobe"}, {31'd0, bus.guessStrobe}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({v.name, ".idle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic ok;
        vecs[0] = '{"s0xB",  4'hB, M_GAME, 1'b1, 1'b0, 3'd2, 4'd11, 20'h0007B};
        vecs[1] = '{"s0x0",  4'h0, M_GAME, 1'b1, 1'b0, 3'd4, 4'd0,  20'h07310};
        vecs[2] = '{"s0xF",  4'hF, M_GAME, 1'b1, 1'b0, 3'd5, 4'd15, 20'h7BDEF};
        vecs[3] = '{"badseg",4'h5, M_BAD,  1'b0, 1'b1, 3'd1, 4'd7,  20'h00007};
        vecs[4] = '{"alwL",  4'h0, M_ALWL, 1'b0, 1'b1, 3'd5, 4'd15, 20'h7BDEF};
        vecs[5] = '{"alwH",  4'h0, M_ALWH, 1'b0, 1'b1, 3'd4, 4'd0,  20'h07310};
        vecs[6] = '{"s0x5",  4'h5, M_GAME, 1'b1, 1'b0, 3'd3, 4'd5,  20'h00735};
        vecs[7] = '{"s0x8",  4'h8, M_GAME, 1'b1, 1'b0, 3'd4, 4'd8,  20'h07B98};

        reset = 1'b1;
        start = 1'b0;
        secret = 4'h0;
        mode = M_GAME;
        repeat (3) @(negedge clk);
        chk("rst.guess", {28'd0, bus.guess}, 32'd0);
        chk("rst.strobe", {31'd0, bus.guessStrobe}, 32'd0);
        chk("rst.count", {29'd0, guessCount}, 32'd0);
        chk("rst.flags", {29'd0, done, win, decodeErr}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_game(vecs[i]);

        // Reset in the WAIT phase of the second guess.
        secret = 4'hB;
        mode = M_GAME;
        start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.guessStrobe && guessCount == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("r6.reach", {31'd0, ok}, 32'd1);
        chk("r6.gap", last_gap, SETTLE + 2);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("r6.guess", {28'd0, bus.guess}, 32'd0);
        chk("r6.count", {29'd0, guessCount}, 32'd0);
        chk("r6.flags", {28'd0, bus.guessStrobe, done, win, decodeErr}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("r6.idle", {29'd0, guessCount, bus.guessStrobe}, 32'd0);
        run_game(vecs[0]);
        chk("strobe.width", wide, 0);
        chk("strobe.spacing", bad_gap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
